// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (start, data LSB first, optional parity, 1-2 stop bits) with valid/ready input buffering.
// Define UART_TX_FIFO_EN to replace the one-word holding register with a FIFO_DEPTH-entry circular FIFO.

module uart_tx_cfg #(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            clk_25mhz,
   input  logic                            reset,
   input  logic [DATA_BITS-1:0]            data,
   input  logic                            valid,
   output logic                            ready,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
   output logic                            tx
);

   localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_d;
   logic [CW-1:0]        baud_cnt, baud_d;
   logic [BW-1:0]        bit_cnt, bit_d;
   logic [DATA_BITS-1:0] shift, shift_d;
   logic                 par_bit, par_d, tx_d;
   logic                 push, pop, buf_empty, next_full, head_par, baud_last;
   logic [DATA_BITS-1:0] head;
   logic [LW-1:0]        next_level;

   assign push      = valid && ready;
   assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign head_par  = (PARITY == 1) ? ~(^head) : ^head;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign wr_ptr_d   = wr_ptr + {{AW{1'b0}}, push};
   assign rd_ptr_d   = rd_ptr + {{AW{1'b0}}, pop};
   assign next_level = wr_ptr_d - rd_ptr_d;
   assign next_full  = (next_level == LW'(FIFO_DEPTH));
   assign level      = wr_ptr - rd_ptr;
   assign buf_empty  = (wr_ptr == rd_ptr);
   assign head       = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (push && !reset) begin
         mem[wr_ptr[AW-1:0]] <= data;
      end
   end
`else
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_full;

   assign next_level = (push || (hold_full && !pop)) ? LW'(1) : '0;
   assign next_full  = (next_level != '0);
   assign level      = {{(LW-1){1'b0}}, hold_full};
   assign buf_empty  = !hold_full;
   assign head       = hold_data;

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         hold_full <= 1'b0;
      end else if (push) begin
         hold_full <= 1'b1;
         hold_data <= data;
      end else if (pop) begin
         hold_full <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         ready    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_cnt  <= bit_d;
         shift    <= shift_d;
         par_bit  <= par_d;
         tx       <= tx_d;
         ready    <= !next_full;
         busy     <= (state_d != IDLE) || (next_level != '0);
      end
   end

   // tx_d is the line value for the cycle after this edge, so tx itself stays a flop.
   always_comb begin
      state_d = state;
      baud_d  = baud_cnt + CW'(1);
      bit_d   = bit_cnt;
      shift_d = shift;
      par_d   = par_bit;
      tx_d    = tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!buf_empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = head_par;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift[0];
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift >> 1;
               if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = PAR;
                     tx_d    = par_bit;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_cnt + BW'(1);
                  tx_d  = shift[1];
               end
            end
         end
         PAR: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_cnt == BW'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  // Chain straight into the next start bit when a word is waiting.
                  if (!buf_empty) begin
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = head_par;
                     state_d = START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_cnt + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg: five instances at 10 clocks per bit covering 8N1, 7E1, 7O1, 7E2 and a depth-4 buffer.
// Expectations adapt to whether UART_TX_FIFO_EN is defined for the build.

module tb_uart_tx_cfg;

   localparam int CPB = 10;
`ifdef UART_TX_FIFO_EN
   localparam bit FIFO_MODE = 1'b1;
   localparam int T5_DEPTH  = 4;
`else
   localparam bit FIFO_MODE = 1'b0;
   localparam int T5_DEPTH  = 1;
`endif

   logic       clk_25mhz = 1'b0;
   logic       reset     = 1'b1;
   logic [7:0] data      = 8'h00;
   logic [4:0] valid_v   = 5'b0;
   logic [4:0] ready_v, busy_v, tx_v;
   logic [4:0] lv0, lv1, lv2, lv3;
   logic [2:0] lv4;
   int checks = 0;
   int errors = 0;

   always #5 clk_25mhz = ~clk_25mhz;

   uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk_25mhz(clk_25mhz), .reset(reset), .data(data), .valid(valid_v[0]),
      .ready(ready_v[0]), .busy(busy_v[0]), .level(lv0), .tx(tx_v[0]));
   uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk_25mhz(clk_25mhz), .reset(reset), .data(data[6:0]), .valid(valid_v[1]),
      .ready(ready_v[1]), .busy(busy_v[1]), .level(lv1), .tx(tx_v[1]));
   uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk_25mhz(clk_25mhz), .reset(reset), .data(data[6:0]), .valid(valid_v[2]),
      .ready(ready_v[2]), .busy(busy_v[2]), .level(lv2), .tx(tx_v[2]));
   uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u3 (
      .clk_25mhz(clk_25mhz), .reset(reset), .data(data[6:0]), .valid(valid_v[3]),
      .ready(ready_v[3]), .busy(busy_v[3]), .level(lv3), .tx(tx_v[3]));
   uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
      .clk_25mhz(clk_25mhz), .reset(reset), .data(data), .valid(valid_v[4]),
      .ready(ready_v[4]), .busy(busy_v[4]), .level(lv4), .tx(tx_v[4]));

   function automatic int level_of(input int idx);
      case (idx)
         0: return int'(lv0);
         1: return int'(lv1);
         2: return int'(lv2);
         3: return int'(lv3);
         default: return int'(lv4);
      endcase
   endfunction

   // Checks tx and busy on every cycle of a frame; bits[0] is the start bit, skip drops leading start cycles.
   task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits, input int skip,
                              input string name);
      for (int b = 0; b < nbits; b++) begin
         for (int c = ((b == 0) ? skip : 0); c < CPB; c++) begin
            checks++;
            if (tx_v[idx] !== bits[b]) begin
               errors++;
               $display("[TB] FAIL %s tx bit %0d cycle %0d: got %b want %b", name, b, c, tx_v[idx], bits[b]);
            end
            checks++;
            if (busy_v[idx] !== 1'b1) begin
               errors++;
               $display("[TB] FAIL %s busy bit %0d cycle %0d: got %b want 1", name, b, c, busy_v[idx]);
            end
            @(negedge clk_25mhz);
         end
      end
   endtask

   task automatic push_word(input int idx, input logic [7:0] word);
      bit r;
      bit done = 1'b0;
      data = word;
      valid_v[idx] = 1'b1;
      for (int k = 0; k < 1000 && !done; k++) begin
         r = ready_v[idx];
         @(negedge clk_25mhz);
         if (r) done = 1'b1;
      end
      valid_v[idx] = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL push_timeout[%0d]: accepted %b want 1", idx, done);
      end
   endtask

   task automatic check_idle(input int idx, input string name);
      checks++;
      if (tx_v[idx] !== 1'b1) begin errors++; $display("[TB] FAIL %s tx: got %b want 1", name, tx_v[idx]); end
      checks++;
      if (busy_v[idx] !== 1'b0) begin errors++; $display("[TB] FAIL %s busy: got %b want 0", name, busy_v[idx]); end
      checks++;
      if (level_of(idx) != 0) begin errors++; $display("[TB] FAIL %s level: got %0d want 0", name, level_of(idx)); end
      checks++;
      if (ready_v[idx] !== 1'b1) begin errors++; $display("[TB] FAIL %s ready: got %b want 1", name, ready_v[idx]); end
   endtask

   // Push one word, confirm it is queued but not yet on the line, then check the full frame and the idle state after it.
   task automatic test_frame(input int idx, input logic [7:0] word, input logic [15:0] bits, input int nbits,
                             input string name);
      push_word(idx, word);
      checks++;
      if (tx_v[idx] !== 1'b1) begin errors++; $display("[TB] FAIL %s early_tx: got %b want 1", name, tx_v[idx]); end
      checks++;
      if (busy_v[idx] !== 1'b1) begin errors++; $display("[TB] FAIL %s busy_on_accept: got %b want 1", name, busy_v[idx]); end
      checks++;
      if (level_of(idx) != 1) begin errors++; $display("[TB] FAIL %s level_on_accept: got %0d want 1", name, level_of(idx)); end
      @(negedge clk_25mhz);
      check_frame(idx, bits, nbits, 0, name);
      check_idle(idx, {name, "_end"});
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      valid_v = 5'b11111;
      data    = 8'hFF;
      repeat (3) @(posedge clk_25mhz);
      @(negedge clk_25mhz);
      for (int i = 0; i < 5; i++) check_idle(i, $sformatf("reset_u%0d", i));
      valid_v = 5'b0;
      reset   = 1'b0;
   endtask

   task automatic test_8n1();
      test_frame(0, 8'h55, 16'h02AA, 10, "8n1_55");
   endtask

   task automatic test_parity();
      test_frame(1, 8'h07, 16'h030E, 10, "7e1_07");
      test_frame(2, 8'h07, 16'h020E, 10, "7o1_07");
      test_frame(3, 8'h07, 16'h070E, 11, "7e2_07");
   endtask

   task automatic test_back_to_back();
      data = 8'hA5;
      valid_v[0] = 1'b1;
      checks++;
      if (ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_before: got %b want 1", ready_v[0]); end
      @(negedge clk_25mhz);
      checks++;
      if (ready_v[0] !== FIFO_MODE) begin errors++; $display("[TB] FAIL b2b_ready_after_push: got %b want %b", ready_v[0], FIFO_MODE); end
      checks++;
      if (lv0 !== 5'd1) begin errors++; $display("[TB] FAIL b2b_level_after_push: got %0d want 1", lv0); end
      checks++;
      if (tx_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tx_after_push: got %b want 1", tx_v[0]); end
      data = 8'h3C;
      @(negedge clk_25mhz);
      checks++;
      if (tx_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tx_fall: got %b want 0", tx_v[0]); end
      checks++;
      if (ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_pop: got %b want 1", ready_v[0]); end
      checks++;
      if (lv0 !== (FIFO_MODE ? 5'd1 : 5'd0)) begin
         errors++; $display("[TB] FAIL b2b_level_after_pop: got %0d want %0d", lv0, FIFO_MODE ? 1 : 0);
      end
      if (FIFO_MODE) valid_v[0] = 1'b0;
      @(negedge clk_25mhz);
      valid_v[0] = 1'b0;
      checks++;
      if (lv0 !== 5'd1) begin errors++; $display("[TB] FAIL b2b_level_second: got %0d want 1", lv0); end
      checks++;
      if (ready_v[0] !== FIFO_MODE) begin errors++; $display("[TB] FAIL b2b_ready_second: got %b want %b", ready_v[0], FIFO_MODE); end
      check_frame(0, 16'h034A, 10, 1, "b2b_a5");
      check_frame(0, 16'h0278, 10, 0, "b2b_3c");
      check_idle(0, "b2b_end");
   endtask

   task automatic test_fifo();
      logic [7:0] w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      int pushed = 0;
      bit saw_full = 1'b0;
      bit r;
      fork
         begin
            valid_v[4] = 1'b1;
            for (int k = 0; k < 2000 && pushed < 6; k++) begin
               data = w[pushed];
               r = ready_v[4];
               if (!r && !saw_full) begin
                  saw_full = 1'b1;
                  checks++;
                  if (lv4 !== 3'(T5_DEPTH)) begin
                     errors++; $display("[TB] FAIL fifo_level_at_full: got %0d want %0d", lv4, T5_DEPTH);
                  end
               end
               @(negedge clk_25mhz);
               if (r) pushed++;
            end
            valid_v[4] = 1'b0;
            checks++;
            if (pushed != 6) begin errors++; $display("[TB] FAIL fifo_push_count: got %0d want 6", pushed); end
            checks++;
            if (!saw_full) begin errors++; $display("[TB] FAIL fifo_ready_fall: got %b want 1", saw_full); end
         end
         begin
            @(negedge clk_25mhz);
            checks++;
            if (tx_v[4] !== 1'b1) begin errors++; $display("[TB] FAIL fifo_early_tx: got %b want 1", tx_v[4]); end
            @(negedge clk_25mhz);
            for (int i = 0; i < 6; i++) begin
               check_frame(4, {6'b0, 1'b1, w[i], 1'b0}, 10, 0, $sformatf("fifo_frame%0d", i));
            end
         end
      join
      check_idle(4, "fifo_end");
   endtask

   task automatic test_reset_mid_frame();
      push_word(0, 8'hFF);
      push_word(0, 8'h12);
      repeat (40) @(negedge clk_25mhz);
      checks++;
      if (lv0 !== 5'd1) begin errors++; $display("[TB] FAIL midrst_level_before: got %0d want 1", lv0); end
      checks++;
      if (busy_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy_v[0]); end
      reset = 1'b1;
      data  = 8'h55;
      valid_v[0] = 1'b1;
      @(negedge clk_25mhz);
      check_idle(0, "midrst_after");
      reset = 1'b0;
      valid_v[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_25mhz);
         checks++;
         if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_stays_idle cycle %0d: got tx=%b busy=%b want tx=1 busy=0", i, tx_v[0], busy_v[0]);
         end
      end
      test_frame(0, 8'h81, 16'h0302, 10, "midrst_81");
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_fifo();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time exceeded 500000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds configurable data width, parity, stop bits and baud rate, plus a valid/ready input handshake with buffering for back-to-back frames. It sits between the on-board logic (clk_25mhz domain) and the FTDI serial TX pin.

Parameters:
CLK_FREQ, 25000000, input clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD (rounded), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries when UART_TX_FIFO_EN is defined; power of 2, >= 2

Ports:
clk_25mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
data  input  DATA_BITS  word to send
valid  input  1  data is valid
ready  output  1  buffer can accept a word
busy  output  1  high while any word is buffered or a frame is on the line
level  output  $clog2(FIFO_DEPTH+1)  number of words buffered, excluding the frame in flight
tx  output  1  serial line, idle high, registered output

Behaviour:
- Reset values (registered on a clk_25mhz edge with reset=1): tx=1, ready=1, busy=0, level=0, FSM=IDLE, baud counter=0, buffer empty. Reset mid-frame aborts the frame: tx returns to 1 at that edge and buffered words are discarded. valid is ignored while reset=1.
- Handshake: a word is accepted on an edge where valid && ready.
  - ready = !full, registered. ready has no combinational dependence on valid or on a same-cycle pop.
  - data must be stable only on the accepting edge.
  - valid while ready=0 is ignored. The word is not stored, and the source must hold it.
- Buffer: one-entry holding register (see Optional Feature). A push and a pop on the same edge are both honoured, and level is unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If the buffer is non-empty at an edge, pop it into the shift register, go to START, and drive tx=0 at that edge. Latency: accept at edge E0 gives tx falling at edge E1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out LSB first, DATA_BITS bits, each held CLKS_PER_BIT cycles. Use a bit counter of width $clog2(DATA_BITS). Then go to PAR if PARITY!=0, otherwise STOP.
  - PAR: tx = XOR of the data bits (even), or its inverse (odd), for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: if the buffer is non-empty, pop and go directly to START (zero idle gap between frames); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and is restarted on every state entry. There is no fractional-rate accumulation.
- busy = (FSM != IDLE) || (buffer non-empty), registered.
- Frame length in cycles = CLKS_PER_BIT * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- Illegal parameter values are rejected at elaboration with $error.

Optional Feature:
UART_TX_FIFO_EN
- Defined: the holding register is replaced by a FIFO_DEPTH-entry circular FIFO.
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits, wrapping at the power of 2.
  - ready=0 exactly when level==FIFO_DEPTH.
  - Push on full is ignored; pop on empty never occurs.
- Undefined: a single holding register is used. level is 0 or 1, and ready = (level==0). One word can be queued while a frame is in flight.

Test Plan:
1. Reset: CLK_FREQ=1000, BAUD=100 (10 clks/bit), reset held 3 cycles -> tx=1, ready=1, busy=0, level=0.
2. 8N1, send 0x55 -> tx falls 1 edge after accept. Line reads 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. busy drops after 100 cycles.
3. PARITY=2, DATA_BITS=7, send 0x07 -> parity bit 1. With PARITY=1 -> parity bit 0. With STOP_BITS=2 -> stop high for 20 cycles, frame 110 cycles.
4. Back-to-back (no FIFO): push 0xA5 then 0x3C with valid held high -> second push stalls (ready=0) until the first frame's START pop. No idle cycle between frames: the stop bit's last cycle is followed directly by the start bit.
5. FIFO_EN, FIFO_DEPTH=4: push 6 words with valid continuously high -> ready falls when level=4. All 6 words appear in order across pointer wrap. level returns to 0, then busy=0.
6. Assert reset mid-DATA of 0xFF -> tx=1 at the next edge, level=0. A subsequent 0x81 transmits correctly.
